pdm_stream_serializer: RTL and testbench

Parametrised successor to the 16-bit audio serializer. It accepts parallel sample words through a valid/ready handshake and buffers them in an internal FIFO. Each word is shifted out one bit at a time on `audio_data`, with a programmable bit period and MSB- or LSB-first order. Words stream back-to-back with no gap cycles. It sits between the sample address/memory reader and the audio output pins, and reports per-word completion and underrun.

---
 rtl/pdm_stream_serializer.sv | 216 +++++++++++++++++++++
 tb/tb_pdm_stream_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_stream_serializer.sv
// pdm_stream_serializer
//   Buffers parallel sample words in a small FIFO and shifts each word out
//   serially on audio_data. Bit period and bit order are programmable and
//   captured per word. Words stream back-to-back with no idle cycles.
//
// Ports
//   clock, reset   system clock; asynchronous active-high reset
//   enable         run control; low aborts the current word and idles
//   lsb_first      bit order, captured at each word load
//   bit_div        bit period = bit_div+1 clocks, captured at each word load
//   in_data/in_valid/in_ready   sample word push handshake
//   audio_enable   copy of enable
//   audio_data     registered serial bit
//   word_done      one-cycle pulse per completed word
//   underrun       one-cycle pulse when a word ends with the FIFO empty
//   fifo_level     words currently buffered
//   bit_count      index of the bit currently on audio_data
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | shifter idle, audio_data low, waiting for enable + data
// ST_LOAD  | next edge pops the FIFO head into the shift register
// ST_SHIFT | word in flight; divider paces bit changes

module pdm_stream_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              lsb_first,
    input  logic [DIV_WIDTH-1:0]              bit_div,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              audio_enable,
    output logic                              audio_data,
    output logic                              word_done,
    output logic                              underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [$clog2(DATA_WIDTH)-1:0]     bit_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // FIFO storage and pointers
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;

    // Shifter
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  div_lat_q, div_lat_d;
    logic                  lsb_lat_q, lsb_lat_d;
    logic                  audio_q, audio_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  word_done_q, word_done_d;
    logic                  underrun_q, underrun_d;

    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] head;

    assign in_ready     = (level_q != FULL_LVL);
    assign push         = in_valid && in_ready;
    assign fifo_empty   = (level_q == '0);
    assign head         = mem_q[rd_ptr_q];

    assign audio_enable = enable;
    assign audio_data   = audio_q;
    assign word_done    = word_done_q;
    assign underrun     = underrun_q;
    assign fifo_level   = level_q;
    assign bit_count    = cnt_q;

    // Shifter control. A final-bit tick with data waiting reloads on the
    // same edge, so consecutive words have no gap.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        div_d       = div_q;
        div_lat_d   = div_lat_q;
        lsb_lat_d   = lsb_lat_q;
        audio_d     = audio_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;
        pop         = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            audio_d = 1'b0;
            cnt_d   = '0;
            div_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_q == div_lat_q) begin
                        if (cnt_q != LAST_BIT) begin
                            audio_d = lsb_lat_q ? shift_q[0] : shift_q[DATA_WIDTH-1];
                            shift_d = lsb_lat_q ? (shift_q >> 1) : (shift_q << 1);
                            cnt_d   = cnt_q + CNT_W'(1);
                            div_d   = '0;
                        end else begin
                            word_done_d = 1'b1;
                            if (!fifo_empty) begin
                                load = 1'b1;
                            end else begin
                                underrun_d = 1'b1;
                                audio_d    = 1'b0;
                                cnt_d      = '0;
                                div_d      = '0;
                                state_d    = ST_IDLE;
                            end
                        end
                    end else begin
                        div_d = div_q + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (load) begin
            pop       = 1'b1;
            lsb_lat_d = lsb_first;
            div_lat_d = bit_div;
            audio_d   = lsb_first ? head[0] : head[DATA_WIDTH-1];
            shift_d   = lsb_first ? (head >> 1) : (head << 1);
            cnt_d     = '0;
            div_d     = '0;
            state_d   = ST_SHIFT;
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Storage is not reset; the pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            div_q       <= '0;
            div_lat_q   <= '0;
            lsb_lat_q   <= 1'b0;
            audio_q     <= 1'b0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            div_lat_q   <= div_lat_d;
            lsb_lat_q   <= lsb_lat_d;
            audio_q     <= audio_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pdm_stream_serializer.sv
module tb_pdm_stream_serializer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        lsb_first;
    logic [7:0]  bit_div;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        audio_enable;
    logic        audio_data;
    logic        word_done;
    logic        underrun;
    logic [2:0]  fifo_level;
    logic [3:0]  bit_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pdm_stream_serializer #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .lsb_first    (lsb_first),
        .bit_div      (bit_div),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .audio_enable (audio_enable),
        .audio_data   (audio_data),
        .word_done    (word_done),
        .underrun     (underrun),
        .fifo_level   (fifo_level),
        .bit_count    (bit_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [15:0] wa;
    logic [15:0] wb;
    logic [15:0] words [4];
    int          wd_cnt;
    int          ur_cnt;
    int          idx;
    logic        exp_bit;

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        lsb_first = 1'b0;
        bit_div   = 8'd0;
        in_data   = 16'h0;
        in_valid  = 1'b0;

        // Reset values before any clock edge
        #2;
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_audio", audio_data, 0);
        check("rst_bit_count", bit_count, 0);
        check("rst_word_done", word_done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_audio_enable", audio_enable, 0);
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        #1;
        check("audio_enable_hi", audio_enable, 1);
        tick();

        // Single word, MSB first, one clock per bit
        wa = 16'hA5C3;
        push_word(wa);
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_bit%0d", i), audio_data, wa[15-i]);
            check($sformatf("t1_cnt%0d", i), bit_count, i);
            check($sformatf("t1_wd%0d", i), word_done, 0);
            tick();
        end
        check("t1_word_done", word_done, 1);
        check("t1_underrun", underrun, 1);
        check("t1_audio_low", audio_data, 0);
        tick();
        check("t1_word_done_off", word_done, 0);
        check("t1_underrun_off", underrun, 0);

        // Two words, LSB first, three clocks per bit
        lsb_first = 1'b1;
        bit_div   = 8'd2;
        wa = 16'hFFFF;
        wb = 16'h0001;
        in_data  = wa;
        in_valid = 1'b1;
        tick();
        in_data = wb;
        tick();
        in_valid = 1'b0;
        tick();
        wd_cnt = 0;
        ur_cnt = 0;
        for (int c = 0; c < 96; c++) begin
            idx = c / 3;
            exp_bit = (idx < 16) ? wa[idx] : wb[idx-16];
            check($sformatf("t2_bit_c%0d", c), audio_data, exp_bit);
            if (word_done) wd_cnt++;
            if (underrun) ur_cnt++;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            if (word_done) wd_cnt++;
            if (underrun) ur_cnt++;
            tick();
        end
        check("t2_word_done_count", wd_cnt, 2);
        check("t2_underrun_count", ur_cnt, 1);

        // Fill the FIFO while disabled, then drain
        enable    = 1'b0;
        lsb_first = 1'b0;
        bit_div   = 8'd0;
        words[0] = 16'h8001;
        words[1] = 16'h4002;
        words[2] = 16'h2004;
        words[3] = 16'h1008;
        for (int i = 0; i < 4; i++) begin
            in_data  = words[i];
            in_valid = 1'b1;
            tick();
            check($sformatf("t3_level%0d", i), fifo_level, i + 1);
            check($sformatf("t3_ready%0d", i), in_ready, (i != 3));
        end
        in_data = 16'hDEAD;
        tick();
        in_valid = 1'b0;
        check("t3_full_level", fifo_level, 4);
        check("t3_full_ready", in_ready, 0);
        check("t3_idle_audio", audio_data, 0);
        enable = 1'b1;
        tick();
        tick();
        wd_cnt = 0;
        ur_cnt = 0;
        for (int c = 0; c < 64; c++) begin
            wa = words[c/16];
            check($sformatf("t3_bit_c%0d", c), audio_data, wa[15 - (c % 16)]);
            if (word_done) wd_cnt++;
            if (underrun) ur_cnt++;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            if (word_done) wd_cnt++;
            if (underrun) ur_cnt++;
            tick();
        end
        check("t3_word_done_count", wd_cnt, 4);
        check("t3_underrun_count", ur_cnt, 1);
        check("t3_level_empty", fifo_level, 0);

        // Abort at bit 7 of 16'h1234, then resume with the next word
        wa = 16'h1234;
        wb = 16'hC001;
        in_data  = wa;
        in_valid = 1'b1;
        tick();
        in_data = wb;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("t4_cnt7", bit_count, 7);
        check("t4_bit7", audio_data, wa[8]);
        enable = 1'b0;
        tick();
        check("t4_abort_audio", audio_data, 0);
        check("t4_abort_cnt", bit_count, 0);
        check("t4_abort_wd", word_done, 0);
        check("t4_abort_level", fifo_level, 1);
        tick();
        check("t4_abort_wd2", word_done, 0);
        check("t4_abort_ur2", underrun, 0);
        enable = 1'b1;
        tick();
        tick();
        check("t4_resume_bit0", audio_data, wb[15]);
        check("t4_resume_cnt0", bit_count, 0);
        check("t4_resume_level", fifo_level, 0);
        tick();
        check("t4_resume_bit1", audio_data, wb[14]);
        check("t4_resume_cnt1", bit_count, 1);
        enable = 1'b0;
        tick();
        tick();

        // Asynchronous reset mid-word with three words buffered
        enable = 1'b1;
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            in_data  = words[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t5_level3", fifo_level, 3);
        check("t5_cnt_mid", bit_count, 1);
        check("t5_audio_mid", audio_data, words[0][14]);
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_audio", audio_data, 0);
        check("t5_rst_cnt", bit_count, 0);
        check("t5_rst_wd", word_done, 0);
        check("t5_rst_ur", underrun, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t5_post_level", fifo_level, 0);
        check("t5_post_audio", audio_data, 0);

        // bit_div changes mid-word: current word keeps 1 clk/bit
        lsb_first = 1'b0;
        bit_div   = 8'd0;
        wa = 16'hF00F;
        wb = 16'h0FF0;
        in_data  = wa;
        in_valid = 1'b1;
        tick();
        in_data = wb;
        tick();
        in_valid = 1'b0;
        tick();
        bit_div = 8'd3;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("t6_w0_bit%0d", c), audio_data, wa[15-c]);
            tick();
        end
        check("t6_w0_done", word_done, 1);
        for (int c = 0; c < 64; c++) begin
            check($sformatf("t6_w1_c%0d", c), audio_data, wb[15 - (c / 4)]);
            check($sformatf("t6_w1_cnt_c%0d", c), bit_count, c / 4);
            tick();
        end
        check("t6_w1_done", word_done, 1);
        check("t6_w1_underrun", underrun, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
